pulse_bram_drain: RTL and testbench
===================================

Name: pulse_bram_drain

Overview:
Downstream consumer of the pulse accumulation BRAM. The generator stage sums fp32 pulse shapes into a NUM_TAPS-word window at byte addresses 0..(NUM_TAPS-1)*ADDR_STRIDE. On every sample tick, this block pops word 0, converts it from fp32 to an unsigned fixed-point DAC code, and shifts the window down by one word. It zero-fills the last word, so the window behaves as a time-ordered output stream. BRAM access is granted through a request/grant handshake shared with the generator.

Parameters:
NUM_TAPS, 13, words in the accumulation window
ADDR_STRIDE, 4, byte stride between BRAM words
SAMPLE_DIV, 100, clk cycles per sample tick (>= 64, so a full drain completes before the next tick)
DAC_WIDTH, 16, output code width
FRAC_BITS, 12, fractional bits of the output code (integer bits = DAC_WIDTH-FRAC_BITS)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  tick counter runs while high; low clears counter and pending tick
bram_req  out  1  request for the BRAM port
bram_gnt  in  1  grant from arbiter; once granted, held until bram_req falls
bram_addr  out  32  byte address
bram_data_in  out  32  write data
bram_we  out  1  write enable
bram_ena  out  1  BRAM enable
bram_data_out  in  32  read data (1-cycle registered BRAM)
sample_out  out  DAC_WIDTH  converted sample, held between updates
sample_valid  out  1  one-cycle strobe when sample_out updates
overrun  out  1  sticky: tick arrived while the previous drain was still pending/active; cleared by rst only

Behaviour:
- Reset (sync, rst=1 at posedge) outputs and state:
  - all outputs 0; state IDLE; tick counter 0; pending 0.
  - BRAM contents untouched.
  - Reset mid-drain abandons the shift and may leave the window partially shifted. This is accepted.
- Tick counter:
  - counts 0..SAMPLE_DIV-1 while enable=1; wraps to 0.
  - at wrap, sets pending.
  - if pending or a drain is already set/active at wrap: overrun<=1 and the tick is dropped; pending stays a single flag.
- FSM states:
  - IDLE: if pending, assert bram_req and go to REQ.
  - REQ: wait for bram_gnt=1. bram_ena/we stay 0 until granted.
  - RD0: addr=0, ena=1, we=0.
  - WAIT0
  - CAP0: register conversion of bram_data_out into sample_out; sample_valid=1 for this one cycle; i<=1.
  - RDi: addr=i*ADDR_STRIDE, we=0.
  - WAITi
  - WRi: addr=(i-1)*ADDR_STRIDE, we=1, data_in=bram_data_out. If i<NUM_TAPS-1, i++ and go to RDi; else go to CLR.
  - CLR: addr=(NUM_TAPS-1)*ADDR_STRIDE, we=1, data_in=0.
  - DONE: ena=0, we=0, bram_req=0, pending=0, return to IDLE.
- Read latency: data is captured exactly 2 cycles after the address is driven (address reg + BRAM reg).
- Drain length: 4 + 3*(NUM_TAPS-1) + 2 cycles after grant = 42 for default.
- bram_gnt dropping mid-drain is an arbiter protocol violation. The block does not re-check grant after REQ.
- enable=0 mid-drain: the drain completes; only the counter and any not-yet-started pending tick are cleared.
- Conversion fp32 -> unsigned Q(DAC_WIDTH-FRAC_BITS).FRAC_BITS, truncating toward zero:
  - sign=1 or exp=0 (zero/denormal) -> 0
  - NaN -> 0
  - +Inf -> all ones
  - value >= 2^(DAC_WIDTH-FRAC_BITS) -> all ones (saturate)
  - otherwise (1.mant) shifted by (exp-127+FRAC_BITS) and truncated.

Decomposition:
- Shared package pulse_pkg: FP32_EXP_BIAS=127, FP32 field slices, drain FSM state enum, default NUM_TAPS/ADDR_STRIDE constants used by generator and drain.
- Sub-module fp32_to_ufix (combinational, parameters DAC_WIDTH, FRAC_BITS); output registered in CAP0.
- Request/grant arbiter bram_port_arb lives at the integration level, not inside this block.

Test Plan:
- BRAM word0=0x3E99652C, arbiter grants immediately, enable=1 -> one tick later sample_out=0x04CB with a single sample_valid, exactly 42 cycles from grant to bram_req low.
- Window preloaded with words k=1.0*(k+1) for k=0..12 -> after one drain, word k equals the old word k+1 and word 12=0; sample_out=0x1000.
- Conversion edges in word0: 0x41800000 (16.0) -> 0xFFFF; 0xBF800000 (-1.0) -> 0; 0x7F800000 -> 0xFFFF; 0x7FC00000 -> 0; 0x00000001 -> 0.
- Grant withheld 3*SAMPLE_DIV cycles -> overrun=1; after grant, exactly one drain runs; overrun stays 1 until rst.
- rst pulsed during WRi -> next cycle all outputs 0, state IDLE; the next tick restarts cleanly from RD0.
- enable=0 for 2*SAMPLE_DIV cycles -> no bram_req, no sample_valid; re-enable -> first tick after exactly SAMPLE_DIV cycles.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse accumulation path: fp32 field layout,
// window geometry defaults and the drain FSM state encoding.
package pulse_pkg;

  localparam int unsigned FP32_EXP_BIAS   = 127;
  localparam int unsigned FP32_EXP_W      = 8;
  localparam int unsigned FP32_MANT_W     = 23;
  localparam int unsigned DEF_NUM_TAPS    = 13;
  localparam int unsigned DEF_ADDR_STRIDE = 4;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  expo;
    logic [FP32_MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD0,
    ST_WAIT0,
    ST_CAP0,
    ST_RDI,
    ST_WAITI,
    ST_WRI,
    ST_CLR,
    ST_DONE
  } drain_state_e;

endpackage

// File: rtl/fp32_to_ufix.sv
// Combinational fp32 -> unsigned fixed-point code, truncating toward zero,
// with negative/zero/denormal/NaN mapped to 0 and overflow/+Inf saturated.
module fp32_to_ufix
  import pulse_pkg::*;
#(
  parameter int unsigned DAC_WIDTH = 16,
  parameter int unsigned FRAC_BITS = 12
) (
  input  logic [31:0]          fp_i,
  output logic [DAC_WIDTH-1:0] code_o
);

  localparam int unsigned INT_BITS = DAC_WIDTH - FRAC_BITS;
  localparam int unsigned SIG_W    = FP32_MANT_W + 1;
  localparam int unsigned WIDE_W   = DAC_WIDTH + SIG_W;

  fp32_t              f;
  logic [SIG_W-1:0]   sig;
  logic signed [10:0] e_unb;
  logic signed [10:0] sh;

  assign f     = fp_i;
  assign sig   = {1'b1, f.mant};
  assign e_unb = $signed({3'b000, f.expo}) - $signed(11'(FP32_EXP_BIAS));
  // Binary point of the 24-bit significand sits FP32_MANT_W bits up.
  assign sh    = e_unb + $signed(11'(FRAC_BITS)) - $signed(11'(FP32_MANT_W));

  always_comb begin
    code_o = '0;
    if (f.sign || (f.expo == '0)) begin
      code_o = '0;
    end else if (f.expo == '1) begin
      code_o = (f.mant == '0) ? '1 : '0;
    end else if (e_unb >= $signed(11'(INT_BITS))) begin
      code_o = '1;
    end else if (!sh[10]) begin
      code_o = DAC_WIDTH'(WIDE_W'(sig) << 11'(sh));
    end else begin
      code_o = DAC_WIDTH'(WIDE_W'(sig) >> 11'(-sh));
    end
  end

endmodule

// File: rtl/pulse_bram_drain.sv
// Pops word 0 of the pulse accumulation window each sample tick, converts it
// to a DAC code and shifts the window down one word, zero-filling the tail.
module pulse_bram_drain
  import pulse_pkg::*;
#(
  parameter int unsigned NUM_TAPS    = DEF_NUM_TAPS,
  parameter int unsigned ADDR_STRIDE = DEF_ADDR_STRIDE,
  parameter int unsigned SAMPLE_DIV  = 100,
  parameter int unsigned DAC_WIDTH   = 16,
  parameter int unsigned FRAC_BITS   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 bram_req,
  input  logic                 bram_gnt,
  output logic [31:0]          bram_addr,
  output logic [31:0]          bram_data_in,
  output logic                 bram_we,
  output logic                 bram_ena,
  input  logic [31:0]          bram_data_out,
  output logic [DAC_WIDTH-1:0] sample_out,
  output logic                 sample_valid,
  output logic                 overrun
);

  localparam int unsigned IDX_W = $clog2(NUM_TAPS);
  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);

  drain_state_e         state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pending_q, pending_d;
  logic                 req_q, req_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          din_q, din_d;
  logic                 we_q, we_d;
  logic                 ena_q, ena_d;
  logic [DAC_WIDTH-1:0] sample_q, sample_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic [DAC_WIDTH-1:0] conv_code;
  logic                 tick_c;

  function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] i);
    return 32'(i) * 32'(ADDR_STRIDE);
  endfunction

  fp32_to_ufix #(
    .DAC_WIDTH (DAC_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_conv (
    .fp_i   (bram_data_out),
    .code_o (conv_code)
  );

  assign tick_c = enable && (cnt_q == CNT_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      we_q      <= 1'b0;
      ena_q     <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      we_q      <= we_d;
      ena_q     <= ena_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    req_d     = req_q;
    addr_d    = '0;
    din_d     = '0;
    we_d      = 1'b0;
    ena_d     = 1'b0;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;

    if (!enable || tick_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // pending doubles as the busy flag until DONE, so a tick now is dropped.
    if (tick_c) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end
    if (!enable && (state_q == ST_IDLE)) begin
      pending_d = 1'b0;
    end

    // Port signals are registered: BRAM sees them the cycle after the state.
    case (state_q)
      ST_IDLE: begin
        if (pending_q && enable) begin
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bram_gnt) begin
          state_d = ST_RD0;
        end
      end
      ST_RD0: begin
        addr_d  = '0;
        ena_d   = 1'b1;
        state_d = ST_WAIT0;
      end
      ST_WAIT0: begin
        state_d = ST_CAP0;
      end
      ST_CAP0: begin
        sample_d = conv_code;
        valid_d  = 1'b1;
        idx_d    = IDX_W'(1);
        state_d  = ST_RDI;
      end
      ST_RDI: begin
        addr_d  = word_addr(idx_q);
        ena_d   = 1'b1;
        state_d = ST_WAITI;
      end
      ST_WAITI: begin
        state_d = ST_WRI;
      end
      ST_WRI: begin
        addr_d = word_addr(idx_q - IDX_W'(1));
        ena_d  = 1'b1;
        we_d   = 1'b1;
        din_d  = bram_data_out;
        if (idx_q < IDX_W'(NUM_TAPS - 1)) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_RDI;
        end else begin
          state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        addr_d  = word_addr(IDX_W'(NUM_TAPS - 1));
        ena_d   = 1'b1;
        we_d    = 1'b1;
        din_d   = '0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        req_d     = 1'b0;
        pending_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bram_req     = req_q;
  assign bram_addr    = addr_q;
  assign bram_data_in = din_q;
  assign bram_we      = we_q;
  assign bram_ena     = ena_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_pulse_bram_drain.sv
// Randomized bench for pulse_bram_drain: BRAM and arbiter models, with a
// window/conversion reference computed from real-valued arithmetic.
module tb_pulse_bram_drain;

  localparam int unsigned NUM_TAPS    = 13;
  localparam int unsigned ADDR_STRIDE = 4;
  localparam int unsigned SAMPLE_DIV  = 100;
  localparam int unsigned DAC_WIDTH   = 16;
  localparam int unsigned FRAC_BITS   = 12;
  localparam int unsigned DRAIN_LEN   = 4 + 3 * (NUM_TAPS - 1) + 2;

  logic                 clk;
  logic                 rst;
  logic                 enable;
  logic                 bram_req;
  logic                 bram_gnt;
  logic [31:0]          bram_addr;
  logic [31:0]          bram_data_in;
  logic                 bram_we;
  logic                 bram_ena;
  logic [31:0]          bram_data_out;
  logic [DAC_WIDTH-1:0] sample_out;
  logic                 sample_valid;
  logic                 overrun;

  logic        gnt_allow;
  logic        ld_en;
  int unsigned ld_idx;
  logic [31:0] ld_val;
  logic [31:0] mem [NUM_TAPS];
  logic [31:0] dout = '0;
  int          bad_addr = 0;
  logic [31:0] win [NUM_TAPS];

  int          gnt_tot = 0;
  int          vcnt_tot = 0;
  int          rise_tot = 0;
  logic        req_prev = 1'b0;
  logic [15:0] last_sample = '0;

  int n_checks = 0;
  int n_errors = 0;

  pulse_bram_drain #(
    .NUM_TAPS    (NUM_TAPS),
    .ADDR_STRIDE (ADDR_STRIDE),
    .SAMPLE_DIV  (SAMPLE_DIV),
    .DAC_WIDTH   (DAC_WIDTH),
    .FRAC_BITS   (FRAC_BITS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .bram_req      (bram_req),
    .bram_gnt      (bram_gnt),
    .bram_addr     (bram_addr),
    .bram_data_in  (bram_data_in),
    .bram_we       (bram_we),
    .bram_ena      (bram_ena),
    .bram_data_out (bram_data_out),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bram_gnt      = bram_req & gnt_allow;
  assign bram_data_out = dout;

  // Single-port BRAM with registered read; bench preload has priority.
  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_val;
    end else if (bram_ena) begin
      if ((bram_addr % ADDR_STRIDE) != 0 || (bram_addr / ADDR_STRIDE) >= NUM_TAPS) begin
        bad_addr <= bad_addr + 1;
      end else if (bram_we) begin
        mem[bram_addr / ADDR_STRIDE] <= bram_data_in;
      end else begin
        dout <= mem[bram_addr / ADDR_STRIDE];
      end
    end
  end

  always @(negedge clk) begin
    if (bram_req && bram_gnt) gnt_tot++;
    if (sample_valid) begin
      vcnt_tot++;
      last_sample = sample_out;
    end
    if (bram_req && !req_prev) rise_tot++;
    req_prev = bram_req;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: value = (1 + m/2^23) * 2^(e-127), code = floor(value * 2^FRAC_BITS).
  function automatic logic [15:0] conv_ref(input logic [31:0] w);
    int  e;
    real v;
    e = int'(w[30:23]);
    if (e == 255) return (w[22:0] == 0 && !w[31]) ? 16'hFFFF : 16'h0000;
    if (w[31] || e == 0) return 16'h0000;
    v = 1.0 + real'(w[22:0]) / 8388608.0;
    if (e >= 127) for (int i = 0; i < e - 127; i++) v = v * 2.0;
    else          for (int i = 0; i < 127 - e; i++) v = v / 2.0;
    v = v * real'(1 << FRAC_BITS);
    if (v >= real'(1 << DAC_WIDTH)) return 16'hFFFF;
    return 16'($rtoi(v));
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: begin w[31] = 1'b0; w[30:23] = 8'($urandom_range(115, 131)); end
      1: w[30:23] = 8'($urandom_range(100, 140));
      default: ;
    endcase
    return w;
  endfunction

  task automatic load_window();
    for (int k = 0; k < NUM_TAPS; k++) begin
      @(negedge clk);
      ld_en  = 1'b1;
      ld_idx = k;
      ld_val = win[k];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic fill_random(input logic [31:0] w0);
    win[0] = w0;
    for (int k = 1; k < NUM_TAPS; k++) win[k] = $urandom;
    load_window();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req"},   32'(bram_req), 0);
    chk({tag, "_addr"},  bram_addr, 0);
    chk({tag, "_din"},   bram_data_in, 0);
    chk({tag, "_we"},    32'(bram_we), 0);
    chk({tag, "_ena"},   32'(bram_ena), 0);
    chk({tag, "_samp"},  32'(sample_out), 0);
    chk({tag, "_valid"}, 32'(sample_valid), 0);
    chk({tag, "_ovr"},   32'(overrun), 0);
  endtask

  task automatic wait_req(input logic level, input int bound, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bram_req !== level && cyc < bound);
  endtask

  task automatic chk_result(input string tag, input int g0, input int v0,
                            input logic [15:0] exp_s, input logic [31:0] exp_win [NUM_TAPS]);
    chk({tag, "_drain_len"}, 32'(gnt_tot - g0), DRAIN_LEN);
    chk({tag, "_nvalid"},    32'(vcnt_tot - v0), 1);
    chk({tag, "_sample"},    32'(last_sample), 32'(exp_s));
    chk({tag, "_held"},      32'(sample_out), 32'(exp_s));
    for (int k = 0; k < NUM_TAPS; k++) begin
      chk($sformatf("%s_word%0d", tag, k), mem[k], exp_win[k]);
      win[k] = exp_win[k];
    end
  endtask

  task automatic expect_window(output logic [15:0] exp_s, output logic [31:0] exp_win [NUM_TAPS]);
    exp_s = conv_ref(win[0]);
    for (int k = 0; k < NUM_TAPS; k++) exp_win[k] = (k < NUM_TAPS - 1) ? win[k + 1] : 32'h0;
  endtask

  // One tick from a cleared counter: enable, expect a tick, full drain, disable.
  task automatic do_drain(input string tag);
    logic [15:0] exp_s;
    logic [31:0] exp_win [NUM_TAPS];
    int g0, v0, cyc;
    expect_window(exp_s, exp_win);
    g0 = gnt_tot;
    v0 = vcnt_tot;
    @(negedge clk);
    enable = 1'b1;
    wait_req(1'b1, 4 * SAMPLE_DIV, cyc);
    chk({tag, "_tick_lat"}, 32'(cyc), SAMPLE_DIV + 1);
    wait_req(1'b0, 4 * DRAIN_LEN, cyc);
    chk({tag, "_req_drop"}, 32'(bram_req), 0);
    enable = 1'b0;
    @(negedge clk);
    chk_result(tag, g0, v0, exp_s, exp_win);
  endtask

  initial begin
    logic [31:0] ones [NUM_TAPS] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                     32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                                     32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                                     32'h41500000};
    logic [31:0] edges [5] = '{32'h41800000, 32'hBF800000, 32'h7F800000, 32'h7FC00000, 32'h00000001};
    logic [15:0] edge_exp [5] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    logic [15:0] exp_s;
    logic [31:0] exp_win [NUM_TAPS];
    int g0, v0, r0, cyc, k;

    rst = 1'b1; enable = 1'b0; gnt_allow = 1'b1; ld_en = 1'b0; ld_idx = 0; ld_val = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;

    fill_random(32'h3E99652C);
    do_drain("basic");
    chk("basic_code", 32'(sample_out), 32'h04CB);

    for (int i = 0; i < NUM_TAPS; i++) win[i] = ones[i];
    load_window();
    do_drain("ramp");
    chk("ramp_code", 32'(sample_out), 32'h1000);

    for (int i = 0; i < 5; i++) begin
      fill_random(edges[i]);
      do_drain($sformatf("edge%0d", i));
      chk($sformatf("edge%0d_code", i), 32'(sample_out), 32'(edge_exp[i]));
    end

    for (int i = 0; i < 8; i++) begin
      fill_random(rand_word());
      do_drain($sformatf("rand%0d", i));
    end

    // Disabled: no ticks at all, then the re-enabled tick lands on time.
    r0 = rise_tot; v0 = vcnt_tot;
    repeat (2 * SAMPLE_DIV) @(negedge clk);
    chk("dis_no_req", 32'(rise_tot - r0), 0);
    chk("dis_no_valid", 32'(vcnt_tot - v0), 0);
    fill_random(rand_word());
    do_drain("reen");

    // Grant withheld across several ticks.
    fill_random(rand_word());
    expect_window(exp_s, exp_win);
    g0 = gnt_tot; v0 = vcnt_tot; r0 = rise_tot;
    @(negedge clk);
    gnt_allow = 1'b0;
    enable = 1'b1;
    repeat (3 * SAMPLE_DIV) @(negedge clk);
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_req_held", 32'(bram_req), 1);
    chk("ovr_no_valid", 32'(vcnt_tot - v0), 0);
    gnt_allow = 1'b1;
    enable = 1'b0;
    wait_req(1'b0, 4 * DRAIN_LEN, cyc);
    chk("ovr_req_drop", 32'(bram_req), 0);
    @(negedge clk);
    chk_result("ovr", g0, v0, exp_s, exp_win);
    repeat (2 * SAMPLE_DIV) @(negedge clk);
    chk("ovr_one_drain", 32'(rise_tot - r0), 1);
    chk("ovr_sticky", 32'(overrun), 1);

    // Reset in the middle of a write step.
    fill_random(rand_word());
    @(negedge clk);
    enable = 1'b1;
    wait_req(1'b1, 4 * SAMPLE_DIV, cyc);
    chk("mid_req_seen", 32'(bram_req), 1);
    k = $urandom_range(1, NUM_TAPS - 1);
    repeat (3 * k + 3) @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk_idle("mid_rst");
    rst = 1'b0;
    fill_random(rand_word());
    do_drain("post_rst");

    chk("bram_addr_range", 32'(bad_addr), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
